wash_state_controller: RTL and testbench
========================================

# wash_state_controller

Top-level sequencer for the washing machine. It converts the front-panel buttons, the door sensor and the run-controller status outputs into the 3-bit machine `state` that drives the run controller, display and buzzer. It sits between the panel I/O and the run controller. It owns every state transition: power-up countdown, setup, run, pause, door error, finish countdown and auto-shutdown.

## Interface
- `IDLE_SEC`, default 10: number of `tick` pulses in setST with no button press before automatic shutdown (1..255).
- `clk`  in  1: system clock.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `tick`  in  1: one-`clk`-cycle pulse once per second, synchronous to `clk`.
- `btn_power`  in  1: raw power button, asynchronous, active-high.
- `btn_start`  in  1: raw start/pause button, asynchronous, active-high.
- `door_open`  in  1: door sensor, asynchronous, 1 = open.
- `had_finish`  in  1: run controller reports the programme is exhausted.
- `init_time`  in  3: run-controller power-up countdown value.
- `finish_time`  in  3: run-controller finish countdown value.
- `state`  out  3: shutDownST=0, beginST=1, setST=2, runST=3, errorST=4, pauseST=5, finishST=6. Value 7 is never driven.
- `state_change`  out  1: one-cycle pulse on the cycle after `state` changes.
- `buzzer`  out  1: high while `state` is errorST or finishST.

## Operation
- Input conditioning:
  - `btn_power`, `btn_start` and `door_open` each pass through a 2-flop synchronizer.
  - Each button has a rising-edge detector that gives a one-cycle `pwr_p` / `start_p` pulse. A held button produces exactly one pulse.
  - `door_s` is the synchronized level.
  - `had_finish`, `init_time` and `finish_time` change only on second boundaries. They are sampled directly.
- Transition priority, evaluated every `clk` cycle in this order:
  1. `pwr_p`: shutDownST goes to beginST. Any other state goes to shutDownST.
  2. In runST, `door_s`=1 goes to errorST.
  3. State-specific rules:
     - shutDownST: waits for `pwr_p` only.
     - beginST: `init_time`==0 goes to setST.
     - setST: `start_p` with `door_s`=0 goes to runST. `start_p` with `door_s`=1 goes to errorST. The idle timeout goes to shutDownST.
     - runST: `had_finish`=1 goes to finishST. `start_p` goes to pauseST.
     - pauseST: `start_p` with `door_s`=0 goes to runST. `start_p` with `door_s`=1 goes to errorST.
     - errorST: `door_s`=0 goes to pauseST. Resuming always requires a fresh `start_p`.
     - finishST: `finish_time`==0 goes to shutDownST.
- Idle counter (8 bits):
  - Cleared on entry to setST and on any `start_p` or `pwr_p`.
  - Increments on `tick` only while in setST.
  - When the counter equals `IDLE_SEC`-1 and `tick`=1, the FSM goes to shutDownST. Shutdown therefore happens on the `IDLE_SEC`-th tick after entry.
  - Held at 0 outside setST.
- `buzzer` is a registered decode of the next state. It asserts in the same cycle that `state` enters errorST or finishST.

## Timing
- Reset values: `state`=0, `state_change`=0, `buzzer`=0, idle counter 0, all synchronizer and edge flops 0.
- Deasserting `rst_n` releases the FSM on the next `clk` edge. Asserting `rst_n` mid-operation forces all of the above at once, from any state.
- Button latency:
  - The raw edge, if set up before clk edge k, reaches the second synchronizer flop at k+1.
  - The press pulse is high in cycle k+2.
  - `state` updates at edge k+3.
  - `state_change` is high during the cycle after edge k+3.
- `door_s` has 2 cycles of latency. Status-input conditions act on the next `clk` edge.
- Exactly one transition per cycle; priority resolves simultaneous events:
  - `pwr_p` together with a door open in runST: goes to shutDownST.
  - Door open together with `had_finish`: goes to errorST.
  - `had_finish` together with `start_p`: goes to finishST.
  - Timeout `tick` together with `start_p` in setST: goes to runST, and the counter clears.
- `init_time` or `finish_time` already 0 on entry to beginST or finishST: the FSM leaves on the next cycle.

## Test plan
- Power-up:
  - Stimulus: reset, press power, step `init_time` 5→0 on ticks, hold `door_open`=0, press start.
  - Expected: `state` 0→1 at +3 cycles, then 1→2 one cycle after `init_time`==0, then 2→3 at start+3.
  - Expected: `state_change` pulses once per transition.
- Pause and door error:
  - Stimulus: in runST press start, then open the door, press start, close the door, press start.
  - Expected: 3→5; a press in 5 with the door open gives 5→4 with `buzzer`=1; closing the door gives 4→5 with `buzzer`=0; the final press gives 5→3.
- Idle timeout with `IDLE_SEC`=3:
  - Stimulus: enter setST and apply 3 ticks with no press; in a second run, press start between tick 2 and tick 3.
  - Expected: first run goes 2→0 on the 3rd tick. Second run goes to runST, and no shutdown occurs.
- Finish:
  - Stimulus: in runST raise `had_finish`, then step `finish_time` 5→0.
  - Expected: 3→6 with `buzzer`=1, then 6→0 once `finish_time`==0, and `buzzer` falls in the same cycle.
- Priority and reset:
  - Stimulus: power press and door open together in runST; then `rst_n` low in pauseST; then start held high for 100 cycles.
  - Expected: the simultaneous case goes to 0. Reset gives `state`=0 asynchronously. The held start produces a single transition.

Source files
------------

// File: rtl/wash_state_controller.sv
// Washing-machine top-level sequencer: conditions the panel inputs and owns every
// machine state transition (power-up, setup, run, pause, door error, finish, idle shutdown).
module wash_state_controller #(
    parameter int unsigned IDLE_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_power,
    input  logic       btn_start,
    input  logic       door_open,
    input  logic       had_finish,
    input  logic [2:0] init_time,
    input  logic [2:0] finish_time,
    output logic [2:0] state,
    output logic       state_change,
    output logic       buzzer
);

    localparam int unsigned IDLE_W = 8;

    localparam logic [2:0] SHUTDOWN_ST = 3'd0;
    localparam logic [2:0] BEGIN_ST    = 3'd1;
    localparam logic [2:0] SET_ST      = 3'd2;
    localparam logic [2:0] RUN_ST      = 3'd3;
    localparam logic [2:0] ERROR_ST    = 3'd4;
    localparam logic [2:0] PAUSE_ST    = 3'd5;
    localparam logic [2:0] FINISH_ST   = 3'd6;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_SEC - 1);

    logic pwr_meta, pwr_sync, pwr_prev, pwr_p;
    logic start_meta, start_sync, start_prev, start_p;
    logic door_meta, door_s;

    logic [2:0]        state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_nxt;
    logic              idle_timeout;

    // Two-flop synchronizers plus registered rising-edge pulses for the buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_meta   <= 1'b0;
            pwr_sync   <= 1'b0;
            pwr_prev   <= 1'b0;
            pwr_p      <= 1'b0;
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            start_p    <= 1'b0;
            door_meta  <= 1'b0;
            door_s     <= 1'b0;
        end else begin
            pwr_meta   <= btn_power;
            pwr_sync   <= pwr_meta;
            pwr_prev   <= pwr_sync;
            pwr_p      <= pwr_sync & ~pwr_prev;
            start_meta <= btn_start;
            start_sync <= start_meta;
            start_prev <= start_sync;
            start_p    <= start_sync & ~start_prev;
            door_meta  <= door_open;
            door_s     <= door_meta;
        end
    end

    // Next-state selection in priority order: power, door-in-run, then per-state rules.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        idle_timeout = (state == SET_ST) && tick && (idle_cnt == IDLE_LAST);

        if (pwr_p) begin
            state_nxt = (state == SHUTDOWN_ST) ? BEGIN_ST : SHUTDOWN_ST;
        end else if ((state == RUN_ST) && door_s) begin
            state_nxt = ERROR_ST;
        end else begin
            case (state)
                SHUTDOWN_ST: state_nxt = SHUTDOWN_ST;
                BEGIN_ST: begin
                    if (init_time == 3'd0) state_nxt = SET_ST;
                end
                SET_ST: begin
                    if (start_p)           state_nxt = door_s ? ERROR_ST : RUN_ST;
                    else if (idle_timeout) state_nxt = SHUTDOWN_ST;
                end
                RUN_ST: begin
                    if (had_finish)   state_nxt = FINISH_ST;
                    else if (start_p) state_nxt = PAUSE_ST;
                end
                PAUSE_ST: begin
                    if (start_p) state_nxt = door_s ? ERROR_ST : RUN_ST;
                end
                ERROR_ST: begin
                    if (!door_s) state_nxt = PAUSE_ST;
                end
                FINISH_ST: begin
                    if (finish_time == 3'd0) state_nxt = SHUTDOWN_ST;
                end
                default: state_nxt = SHUTDOWN_ST;
            endcase
        end

        // Idle count only accumulates while staying in setST without any press.
        if ((state_nxt != SET_ST) || (state != SET_ST) || start_p || pwr_p) begin
            idle_cnt_nxt = '0;
        end else if (tick) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end
    end

    // State register with registered change pulse and next-state buzzer decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SHUTDOWN_ST;
            state_change <= 1'b0;
            buzzer       <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            state_change <= (state_nxt != state);
            buzzer       <= (state_nxt == ERROR_ST) || (state_nxt == FINISH_ST);
            idle_cnt     <= idle_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wash_state_controller.sv
// Bench for wash_state_controller: hand-derived vector table, directed corner sequences,
// and randomized stimulus checked every cycle against a history-based reference model.
module tb_wash_state_controller;

    localparam int unsigned IDLE = 3;

    localparam int S_SHUT = 0;
    localparam int S_BEGIN = 1;
    localparam int S_SET = 2;
    localparam int S_RUN = 3;
    localparam int S_ERR = 4;
    localparam int S_PAUSE = 5;
    localparam int S_FIN = 6;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       btn_power;
    logic       btn_start;
    logic       door_open;
    logic       had_finish;
    logic [2:0] init_time;
    logic [2:0] finish_time;
    logic [2:0] state;
    logic       state_change;
    logic       buzzer;

    int n_checks;
    int n_fail;

    wash_state_controller #(.IDLE_SEC(IDLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn_power    (btn_power),
        .btn_start    (btn_start),
        .door_open    (door_open),
        .had_finish   (had_finish),
        .init_time    (init_time),
        .finish_time  (finish_time),
        .state        (state),
        .state_change (state_change),
        .buzzer       (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw input history per edge, machine state and ticks spent idle in setST.
    bit ph[4];
    bit sh[4];
    bit dh[2];
    int m_state;
    int m_idle_ticks;
    bit m_chg;
    bit m_buz;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ph[i] = 1'b0;
            sh[i] = 1'b0;
        end
        dh[0] = 1'b0;
        dh[1] = 1'b0;
        m_state = S_SHUT;
        m_idle_ticks = 0;
        m_chg = 1'b0;
        m_buz = 1'b0;
    endtask

    // A press acts three edges after the raw level is first sampled; the door acts two edges later.
    task automatic model_step();
        bit pwr_press, start_press, door_closed_view, door_is_open, timed_out;
        int nxt;
        pwr_press   = ph[2] && !ph[3];
        start_press = sh[2] && !sh[3];
        door_is_open = dh[1];
        door_closed_view = !door_is_open;
        timed_out = (m_state == S_SET) && (tick == 1'b1) && (m_idle_ticks + 1 == int'(IDLE));
        nxt = m_state;
        if (pwr_press) begin
            nxt = (m_state == S_SHUT) ? S_BEGIN : S_SHUT;
        end else if (m_state == S_RUN && door_is_open) begin
            nxt = S_ERR;
        end else if (m_state == S_BEGIN) begin
            if (init_time == 3'd0) nxt = S_SET;
        end else if (m_state == S_SET) begin
            if (start_press) nxt = door_is_open ? S_ERR : S_RUN;
            else if (timed_out) nxt = S_SHUT;
        end else if (m_state == S_RUN) begin
            if (had_finish) nxt = S_FIN;
            else if (start_press) nxt = S_PAUSE;
        end else if (m_state == S_PAUSE) begin
            if (start_press) nxt = door_is_open ? S_ERR : S_RUN;
        end else if (m_state == S_ERR) begin
            if (door_closed_view) nxt = S_PAUSE;
        end else if (m_state == S_FIN) begin
            if (finish_time == 3'd0) nxt = S_SHUT;
        end
        if (nxt == S_SET && m_state == S_SET && !pwr_press && !start_press) begin
            if (tick) m_idle_ticks = m_idle_ticks + 1;
        end else begin
            m_idle_ticks = 0;
        end
        m_chg = (nxt != m_state);
        m_buz = (nxt == S_ERR) || (nxt == S_FIN);
        m_state = nxt;
        for (int i = 3; i > 0; i--) begin
            ph[i] = ph[i-1];
            sh[i] = sh[i-1];
        end
        ph[0] = btn_power;
        sh[0] = btn_start;
        dh[1] = dh[0];
        dh[0] = door_open;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_state", int'(state), m_state);
        check("model_state_change", int'(state_change), int'(m_chg));
        check("model_buzzer", int'(buzzer), int'(m_buz));
    endtask

    task automatic press_power();
        btn_power = 1'b1;
        cycle();
        btn_power = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cycle();
        btn_start = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic one_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic       pwr;
        logic       start;
        logic       door;
        logic [2:0] init;
        logic [2:0] exp_state;
        logic       exp_chg;
        logic       exp_buz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic p, input logic s, input logic d, input logic [2:0] it,
                       input logic [2:0] st, input logic c, input logic b);
        vec_t v;
        v.pwr = p; v.start = s; v.door = d; v.init = it;
        v.exp_state = st; v.exp_chg = c; v.exp_buz = b;
        vq.push_back(v);
    endtask

    initial begin
        int n_held;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        tick = 1'b0;
        btn_power = 1'b0;
        btn_start = 1'b0;
        door_open = 1'b0;
        had_finish = 1'b0;
        init_time = 3'd5;
        finish_time = 3'd7;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_state_change", int'(state_change), 0);
        check("reset_buzzer", int'(buzzer), 0);
        rst_n = 1'b1;

        // Power-up, start, door error and recovery, one row per clock edge.
        add(1,0,0,5, 0,0,0); add(1,0,0,5, 0,0,0); add(1,0,0,5, 0,0,0);
        add(0,0,0,5, 1,1,0); add(0,0,0,0, 2,1,0); add(0,0,0,0, 2,0,0);
        add(0,1,0,0, 2,0,0); add(0,0,0,0, 2,0,0); add(0,0,0,0, 2,0,0);
        add(0,0,0,0, 3,1,0); add(0,0,0,0, 3,0,0); add(0,0,1,0, 3,0,0);
        add(0,0,1,0, 3,0,0); add(0,0,1,0, 4,1,1); add(0,0,0,0, 4,0,1);
        add(0,0,0,0, 4,0,1); add(0,0,0,0, 5,1,0); add(0,0,0,0, 5,0,0);
        for (int i = 0; i < vq.size(); i++) begin
            btn_power = vq[i].pwr;
            btn_start = vq[i].start;
            door_open = vq[i].door;
            init_time = vq[i].init;
            cycle();
            check($sformatf("vec%0d_state", i), int'(state), int'(vq[i].exp_state));
            check($sformatf("vec%0d_change", i), int'(state_change), int'(vq[i].exp_chg));
            check($sformatf("vec%0d_buzzer", i), int'(buzzer), int'(vq[i].exp_buz));
        end

        press_power();
        check("pause_power_off", int'(state), S_SHUT);

        // Idle timeout on the third tick in setST.
        init_time = 3'd0;
        press_power();
        cycle();
        check("idle_enter_set", int'(state), S_SET);
        one_tick();
        one_tick();
        check("idle_after_two_ticks", int'(state), S_SET);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("idle_timeout", int'(state), S_SHUT);

        // Start press coinciding with the timeout tick wins.
        press_power();
        cycle();
        one_tick();
        one_tick();
        btn_start = 1'b1;
        cycle();
        btn_start = 1'b0;
        cycle();
        cycle();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("tick_with_start", int'(state), S_RUN);
        one_tick();
        check("no_shutdown_in_run", int'(state), S_RUN);

        // Pause, door error, recovery, resume.
        press_start();
        check("run_to_pause", int'(state), S_PAUSE);
        door_open = 1'b1;
        cycle();
        cycle();
        press_start();
        check("pause_to_error", int'(state), S_ERR);
        check("error_buzzer", int'(buzzer), 1);
        door_open = 1'b0;
        repeat (3) cycle();
        check("error_to_pause", int'(state), S_PAUSE);
        check("pause_buzzer", int'(buzzer), 0);
        press_start();
        check("pause_to_run", int'(state), S_RUN);

        // Finish countdown.
        finish_time = 3'd5;
        had_finish = 1'b1;
        cycle();
        had_finish = 1'b0;
        check("run_to_finish", int'(state), S_FIN);
        check("finish_buzzer", int'(buzzer), 1);
        for (int f = 4; f >= 1; f--) begin
            finish_time = 3'(f);
            one_tick();
        end
        check("finish_hold", int'(state), S_FIN);
        finish_time = 3'd0;
        cycle();
        check("finish_to_off", int'(state), S_SHUT);
        check("finish_buzzer_off", int'(buzzer), 0);
        check("finish_change", int'(state_change), 1);

        // Power press and door opening land on the same edge in runST.
        press_power();
        cycle();
        press_start();
        check("prio_in_run", int'(state), S_RUN);
        btn_power = 1'b1;
        cycle();
        btn_power = 1'b0;
        door_open = 1'b1;
        cycle();
        cycle();
        check("prio_before", int'(state), S_RUN);
        cycle();
        check("pwr_vs_door", int'(state), S_SHUT);
        door_open = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset while paused.
        press_power();
        cycle();
        press_start();
        press_start();
        check("reset_pre_pause", int'(state), S_PAUSE);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", int'(state), 0);
        check("async_reset_change", int'(state_change), 0);
        check("async_reset_buzzer", int'(buzzer), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A held start button produces a single transition.
        press_power();
        cycle();
        check("held_enter_set", int'(state), S_SET);
        btn_start = 1'b1;
        n_held = 0;
        repeat (100) begin
            cycle();
            if (state_change) n_held++;
        end
        btn_start = 1'b0;
        check("held_start_transitions", n_held, 1);
        check("held_start_state", int'(state), S_RUN);

        // Randomized stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 50) == 0) btn_power = ~btn_power;
            if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 30) == 0) door_open = ~door_open;
            tick = ($urandom_range(0, 7) == 0);
            if (tick) begin
                had_finish = ($urandom_range(0, 3) == 0);
                init_time = 3'($urandom_range(0, 2));
                finish_time = 3'($urandom_range(0, 2));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
